// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared address width, zero word, default index width and derived tag width
package branch_predictor_pkg;
  localparam int AddrLen = 32;
  localparam logic [AddrLen-1:0] ZERO_WORD = '0;
  localparam int BP_IDX_W_DEF = 7;
  function automatic int tag_w(input int idx_w);
    return AddrLen - idx_w - 2;
  endfunction
endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// bp_sat_ctr: 2-bit saturating counter step (cur, taken -> next)
module bp_sat_ctr (
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);
  always_comb next = taken ? ((cur == 2'd3) ? cur : cur + 2'd1) : ((cur == 2'd0) ? cur : cur - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; query_* -> registered pred_*, upd_* trains table, upd_cnt/mispred_cnt statistics; rst async active-low, rdy stalls everything
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BP_IDX_W = BP_IDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               query_valid,
  input  logic [AddrLen-1:0] query_pc,
  output logic               pred_jump_or_not,
  output logic [AddrLen-1:0] pred_pc,
  input  logic               upd_valid,
  input  logic [AddrLen-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic [AddrLen-1:0] upd_target,
  input  logic               upd_failed,
  output logic [31:0]        upd_cnt,
  output logic [31:0]        mispred_cnt
);
  localparam int N  = 1 << BP_IDX_W;
  localparam int TW = tag_w(BP_IDX_W);
  logic               valid_q [N];
  logic [TW-1:0]      tag_q   [N];
  logic [AddrLen-1:0] tgt_q   [N];
  logic [1:0]         ctr_q   [N];
  logic [BP_IDX_W-1:0] q_idx, u_idx;
  logic [TW-1:0]       q_tag, u_tag;
  logic                q_taken, u_hit;
  logic [1:0]          ctr_next;
  assign q_idx   = query_pc[BP_IDX_W+1:2];
  assign q_tag   = query_pc[AddrLen-1:BP_IDX_W+2];
  assign u_idx   = upd_pc[BP_IDX_W+1:2];
  assign u_tag   = upd_pc[AddrLen-1:BP_IDX_W+2];
  assign q_taken = valid_q[q_idx] && tag_q[q_idx] == q_tag && ctr_q[q_idx][1];
  assign u_hit   = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  bp_sat_ctr u_sat (.cur(ctr_q[u_idx]), .taken(upd_taken), .next(ctr_next));
  // query reads the pre-edge table, so a same-index update is only visible to later queries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= ZERO_WORD;
        ctr_q[i]   <= 2'd1;
      end
      pred_jump_or_not <= 1'b0;
      pred_pc          <= ZERO_WORD;
      upd_cnt          <= '0;
      mispred_cnt      <= '0;
    end else if (rdy) begin
      pred_jump_or_not <= query_valid && q_taken;
      if (query_valid) pred_pc <= q_taken ? tgt_q[q_idx] : query_pc + AddrLen'(4);
      if (upd_valid) begin
        upd_cnt <= upd_cnt + 32'd1;
        if (upd_failed) mispred_cnt <= mispred_cnt + 32'd1;
        if (u_hit) begin
          ctr_q[u_idx] <= ctr_next;
          if (upd_taken) tgt_q[u_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= upd_target;
          ctr_q[u_idx]   <= 2'd2;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed + randomized check of branch_predictor against a table model
module tb_branch_predictor;
  localparam int IW = 7;
  localparam int N  = 1 << IW;
  logic        clk = 1'b0;
  logic        rst, rdy, query_valid, upd_valid, upd_taken, upd_failed;
  logic [31:0] query_pc, upd_pc, upd_target, pred_pc, upd_cnt, mispred_cnt;
  logic        pred_jump_or_not;
  int          checks = 0;
  int          failures = 0;
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic        exp_j;
  logic [31:0] exp_pc, exp_upd, exp_mis;

  branch_predictor dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .query_valid(query_valid), .query_pc(query_pc),
    .pred_jump_or_not(pred_jump_or_not), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_failed(upd_failed),
    .upd_cnt(upd_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    exp_j = 0; exp_pc = 0; exp_upd = 0; exp_mis = 0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % N);
    return m_valid[idx] && m_tag[idx] == (pc >> (IW + 2));
  endfunction

  task automatic cyc(input logic r, input logic qv, input logic [31:0] qpc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic uf, input string tag);
    int qi, ui;
    rdy = r; query_valid = qv; query_pc = qpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_failed = uf;
    qi = int'((qpc >> 2) % N);
    ui = int'((upc >> 2) % N);
    if (r) begin
      if (qv) begin
        exp_j  = m_hit(qpc) && m_ctr[qi] >= 2;
        exp_pc = exp_j ? m_tgt[qi] : qpc + 32'd4;
      end else exp_j = 0;
      if (uv) begin
        exp_upd = exp_upd + 1;
        if (uf) exp_mis = exp_mis + 1;
        if (m_hit(upc)) begin
          m_ctr[ui] = ut ? ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1) : ((m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1);
          if (ut) m_tgt[ui] = utgt;
        end else if (ut) begin
          m_valid[ui] = 1; m_tag[ui] = upc >> (IW + 2); m_tgt[ui] = utgt; m_ctr[ui] = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".jump"}, {31'd0, pred_jump_or_not}, {31'd0, exp_j});
    chk({tag, ".pc"}, pred_pc, exp_pc);
    chk({tag, ".upd_cnt"}, upd_cnt, exp_upd);
    chk({tag, ".mispred_cnt"}, mispred_cnt, exp_mis);
  endtask

  task automatic q(input logic [31:0] pc, input string tag);
    cyc(1, 1, pc, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic u(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input string tag);
    cyc(1, 0, 0, 1, pc, t, tgt, 0, tag);
  endtask

  initial begin
    rst = 1'b0; rdy = 1; query_valid = 0; query_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_failed = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.jump", {31'd0, pred_jump_or_not}, 32'd0);
    chk("reset.pc", pred_pc, 32'd0);
    chk("reset.upd_cnt", upd_cnt, 32'd0);
    chk("reset.mispred_cnt", mispred_cnt, 32'd0);
    rst = 1'b1;
    q(32'h100, "cold_query");
    chk("cold_pc_direct", pred_pc, 32'h104);
    u(32'h100, 1, 32'h200, "alloc");
    q(32'h100, "hit_taken");
    chk("hit_pc_direct", pred_pc, 32'h200);
    for (int i = 0; i < 4; i++) u(32'h100, 0, 32'h0, "dec");
    q(32'h100, "sat_low");
    chk("sat_low_direct", {31'd0, pred_jump_or_not}, 32'd0);
    u(32'h100, 1, 32'h240, "inc1");
    q(32'h100, "weak_nt");
    for (int i = 0; i < 4; i++) u(32'h100, 1, 32'h280, "inc");
    q(32'h100, "sat_high");
    u(32'h100, 0, 32'h0, "dec_from3");
    q(32'h100, "still_taken");
    chk("still_taken_pc", pred_pc, 32'h280);
    u(32'h300, 1, 32'h500, "alias_alloc");
    q(32'h100, "alias_miss");
    chk("alias_miss_direct", pred_pc, 32'h104);
    q(32'h300, "alias_hit");
    chk("alias_hit_direct", pred_pc, 32'h500);
    u(32'h304, 0, 32'h0, "nt_miss_noalloc");
    q(32'h304, "nt_miss_query");
    cyc(1, 0, 32'h300, 0, 0, 0, 0, 0, "idle_clear");
    // mid-operation reset drops the concurrent update
    rdy = 1; upd_valid = 1; upd_pc = 32'h400; upd_taken = 1; upd_target = 32'h600; upd_failed = 1;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst.jump", {31'd0, pred_jump_or_not}, 32'd0);
    chk("midrst.upd_cnt", upd_cnt, 32'd0);
    rst = 1'b1;
    q(32'h400, "post_rst_query");
    chk("post_rst_pc", pred_pc, 32'h404);
    cyc(1, 1, 32'h100, 1, 32'h100, 1, 32'h200, 1, "same_edge");
    chk("same_edge_direct", {31'd0, pred_jump_or_not}, 32'd0);
    q(32'h100, "after_same_edge");
    chk("after_same_edge_direct", {31'd0, pred_jump_or_not}, 32'd1);
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 32'h100, 1, 32'h100, 0, 32'h0, 1, "stall");
    q(32'h100, "after_stall");
    force dut.mispred_cnt = 32'hFFFF_FFFF;
    #1 release dut.mispred_cnt;
    exp_mis = 32'hFFFF_FFFF;
    cyc(1, 0, 0, 1, 32'h800, 0, 0, 1, "mis_wrap");
    chk("mis_wrap_direct", mispred_cnt, 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] qa, ua;
      qa = ($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2);
      ua = ($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2);
      cyc($urandom_range(0, 9) != 0, 1'($urandom), qa, 1'($urandom), ua, 1'($urandom),
          {$urandom_range(0, 16383), 2'b00}, 1'($urandom), "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
